// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: shadow pipeline, load-use stall, forwarding select, multi-cycle FPU stall FSM, branch flush.
// Define FLOAT_RF_EN to track a separate float register file (f0 is a real register).
module pipe_hazard_ctrl #(
    parameter int STAGES      = 3,
    parameter int BR_STAGE    = 2,
    parameter int RAW         = 5,
    parameter int FPU_MAX_CYC = 16
) (
    input  logic                          clock,
    input  logic                          clear,
    input  logic                          id_valid,
    input  logic [RAW-1:0]                id_rd,
    input  logic [RAW-1:0]                id_rs1,
    input  logic [RAW-1:0]                id_rs2,
    input  logic                          id_rs1_used,
    input  logic                          id_rs2_used,
    input  logic                          id_regwrite,
    input  logic                          id_memread,
    input  logic                          id_fpu_multi,
    input  logic                          id_float_rd,
    input  logic                          id_float_rs1,
    input  logic                          id_float_rs2,
    input  logic                          fpu_done,
    input  logic                          branch_taken,
    output logic                          pc_en,
    output logic                          ifid_en,
    output logic                          ifid_flush,
    output logic                          idex_bubble,
    output logic [STAGES-1:0]             flush_mask,
    output logic [$clog2(STAGES+1)-1:0]   fwd_a,
    output logic [$clog2(STAGES+1)-1:0]   fwd_b,
    output logic                          fpu_busy,
    output logic                          fpu_timeout
);
    localparam int FW = $clog2(STAGES + 1);
    localparam int CW = $clog2(FPU_MAX_CYC);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_n;

    logic id_f_rd, id_f_rs1, id_f_rs2;
`ifdef FLOAT_RF_EN
    assign id_f_rd  = id_float_rd;
    assign id_f_rs1 = id_float_rs1;
    assign id_f_rs2 = id_float_rs2;
`else
    assign id_f_rd  = 1'b0;
    assign id_f_rs1 = 1'b0;
    assign id_f_rs2 = 1'b0;
    logic unused_float;
    assign unused_float = id_float_rd ^ id_float_rs1 ^ id_float_rs2;
`endif

    logic [STAGES:1] e_valid, e_rw, e_mr, e_fpu, e_frd;
    logic [RAW-1:0]  e_rd [1:STAGES];
    logic [STAGES:1] n_valid, n_rw, n_mr, n_fpu, n_frd;
    logic [RAW-1:0]  n_rd [1:STAGES];
    logic [STAGES:1] kill;
    logic [RAW-1:0]  ex_rs1, ex_rs2;
    logic            ex_u1, ex_u2, ex_f1, ex_f2;
    logic [CW-1:0]   cnt, cnt_n;
    logic            hold1, ins_bubble, load_use, fpu_exit, cnt_last;
    logic            unused_tail;

    assign unused_tail = e_mr[STAGES] ^ e_fpu[STAGES];

    // Integer x0 never matches; float f0 does, and the two files never alias.
    function automatic logic reg_match(input logic [RAW-1:0] rd, input logic rd_f,
                                       input logic [RAW-1:0] rs, input logic rs_f);
        return (rd == rs) && (rd_f == rs_f) && (rd_f || (rd != '0));
    endfunction

    assign cnt_last = (cnt == CW'(FPU_MAX_CYC - 1));
    assign fpu_exit = (state == BUSY) && (fpu_done || cnt_last);
    assign load_use = id_valid && e_valid[1] && e_mr[1] &&
                      ((id_rs1_used && reg_match(e_rd[1], e_frd[1], id_rs1, id_f_rs1)) ||
                       (id_rs2_used && reg_match(e_rd[1], e_frd[1], id_rs2, id_f_rs2)));

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        flush_mask  = '0;
        fpu_busy    = 1'b0;
        fpu_timeout = 1'b0;
        kill        = '0;
        hold1       = 1'b0;
        ins_bubble  = 1'b0;
        state_n     = state;
        cnt_n       = cnt;
        if (clear) begin
            fpu_busy = (state == BUSY);
            if (branch_taken) begin
                ifid_flush = 1'b1;
                ins_bubble = 1'b1;
                for (int k = 1; k < BR_STAGE; k++) begin
                    flush_mask[k-1] = 1'b1;
                    kill[k]         = 1'b1;
                end
                if (state == BUSY) kill[1] = 1'b1;
            end else if (state == BUSY) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                fpu_timeout = cnt_last && !fpu_done;
                if (fpu_exit) ins_bubble = 1'b1;
                else          hold1      = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
                ins_bubble  = 1'b1;
            end
            case (state)
                IDLE: if (e_valid[1] && e_fpu[1] && !kill[1]) begin
                    state_n = BUSY;
                    cnt_n   = '0;
                end
                BUSY: if (branch_taken || fpu_exit) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Shadow pipeline advance; stage 2 takes a bubble while the FPU holds stage 1.
    always_comb begin
        n_valid = e_valid;
        n_rw    = e_rw;
        n_mr    = e_mr;
        n_fpu   = e_fpu;
        n_frd   = e_frd;
        n_rd    = e_rd;
        for (int k = 2; k <= STAGES; k++) begin
            n_valid[k] = e_valid[k-1] && !kill[k-1];
            n_rw[k]    = e_rw[k-1];
            n_mr[k]    = e_mr[k-1];
            n_fpu[k]   = e_fpu[k-1];
            n_frd[k]   = e_frd[k-1];
            n_rd[k]    = e_rd[k-1];
        end
        if (hold1) begin
            n_valid[1] = e_valid[1];
            n_rw[1]    = e_rw[1];
            n_mr[1]    = e_mr[1];
            n_fpu[1]   = e_fpu[1];
            n_frd[1]   = e_frd[1];
            n_rd[1]    = e_rd[1];
            n_valid[2] = 1'b0;
        end else begin
            n_valid[1] = id_valid && !ins_bubble;
            n_rw[1]    = id_regwrite;
            n_mr[1]    = id_memread;
            n_fpu[1]   = id_fpu_multi;
            n_frd[1]   = id_f_rd;
            n_rd[1]    = id_rd;
        end
    end

    // Forwarding for the EX sources: nearest (smallest k) producer wins.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        if (clear) begin
            for (int k = STAGES; k >= 2; k--) begin
                if (e_valid[k] && e_rw[k] && ex_u1 && reg_match(e_rd[k], e_frd[k], ex_rs1, ex_f1))
                    fwd_a = FW'(k);
                if (e_valid[k] && e_rw[k] && ex_u2 && reg_match(e_rd[k], e_frd[k], ex_rs2, ex_f2))
                    fwd_b = FW'(k);
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            e_valid <= '0;
            cnt     <= '0;
            ex_u1   <= 1'b0;
            ex_u2   <= 1'b0;
        end else begin
            e_valid <= n_valid;
            cnt     <= cnt_n;
            if (!hold1) begin
                ex_u1 <= id_valid && id_rs1_used;
                ex_u2 <= id_valid && id_rs2_used;
            end
        end
    end

    always_ff @(posedge clock) begin
        e_rw  <= n_rw;
        e_mr  <= n_mr;
        e_fpu <= n_fpu;
        e_frd <= n_frd;
        e_rd  <= n_rd;
        if (!hold1) begin
            ex_rs1 <= id_rs1;
            ex_rs2 <= id_rs2;
            ex_f1  <= id_f_rs1;
            ex_f2  <= id_f_rs2;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (STAGES=3, BR_STAGE=2, FPU_MAX_CYC=16); float cases follow FLOAT_RF_EN.
module tb_pipe_hazard_ctrl;
    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic       id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_memread, id_fpu_multi;
    logic [4:0] id_rd, id_rs1, id_rs2;
    logic       id_float_rd, id_float_rs1, id_float_rs2;
    logic       fpu_done, branch_taken;
    logic       pc_en, ifid_en, ifid_flush, idex_bubble, fpu_busy, fpu_timeout;
    logic [2:0] flush_mask;
    logic [1:0] fwd_a, fwd_b;
    int         n_vec = 0;
    int         n_err = 0;

    pipe_hazard_ctrl #(.STAGES(3), .BR_STAGE(2), .RAW(5), .FPU_MAX_CYC(16)) dut (
        .clock(clock), .clear(clear),
        .id_valid(id_valid), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_fpu_multi(id_fpu_multi),
        .id_float_rd(id_float_rd), .id_float_rs1(id_float_rs1), .id_float_rs2(id_float_rs2),
        .fpu_done(fpu_done), .branch_taken(branch_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .flush_mask(flush_mask), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .fpu_busy(fpu_busy), .fpu_timeout(fpu_timeout)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic nop;
        id_valid = 0; id_rd = 0; id_rs1 = 0; id_rs2 = 0;
        id_rs1_used = 0; id_rs2_used = 0; id_regwrite = 0; id_memread = 0; id_fpu_multi = 0;
        id_float_rd = 0; id_float_rs1 = 0; id_float_rs2 = 0;
    endtask

    task automatic put(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic rw, input logic mr, input logic fm);
        nop;
        id_valid = 1; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_rs1_used = u1; id_rs2_used = u2; id_regwrite = rw; id_memread = mr; id_fpu_multi = fm;
    endtask

    task automatic do_reset;
        clear = 0; nop; branch_taken = 0; fpu_done = 0;
        #1;
        tick;
        clear = 1;
    endtask

    task automatic test_reset;
        clear = 0; put(5, 5, 5, 1, 1, 1, 1, 1); branch_taken = 1; fpu_done = 1;
        #1;
        n_vec++;
        if ({pc_en, ifid_en, ifid_flush, idex_bubble} !== 4'b1100) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 1100", {pc_en, ifid_en, ifid_flush, idex_bubble});
        end
        n_vec++;
        if (flush_mask !== 3'b000) begin
            n_err++; $display("FAIL reset_mask: got %b want 000", flush_mask);
        end
        tick;
        n_vec++;
        if ({fwd_a, fwd_b, fpu_busy, fpu_timeout} !== 6'b0) begin
            n_err++; $display("FAIL reset_fwd_fpu: got %b want 000000", {fwd_a, fwd_b, fpu_busy, fpu_timeout});
        end
        branch_taken = 0; fpu_done = 0; nop; clear = 1;
        tick;
        n_vec++;
        if ({pc_en, ifid_en, fpu_busy} !== 3'b110) begin
            n_err++; $display("FAIL reset_release: got %b want 110", {pc_en, ifid_en, fpu_busy});
        end
    endtask

    task automatic test_load_use;
        do_reset;
        put(5, 1, 0, 1, 0, 1, 1, 0); tick;
        put(6, 5, 1, 1, 1, 1, 0, 0); #1;
        n_vec++;
        if ({pc_en, ifid_en, idex_bubble} !== 3'b001) begin
            n_err++; $display("FAIL load_use_stall: got %b want 001", {pc_en, ifid_en, idex_bubble});
        end
        tick;
        n_vec++;
        if ({pc_en, idex_bubble, fwd_a, fwd_b} !== 6'b10_10_00) begin
            n_err++; $display("FAIL load_use_release: got %b want 101000", {pc_en, idex_bubble, fwd_a, fwd_b});
        end
        tick; nop; #1;
        n_vec++;
        if (fwd_a !== 2'd3) begin
            n_err++; $display("FAIL load_use_fwd3: got %0d want 3", fwd_a);
        end
        do_reset;
        put(0, 1, 0, 1, 0, 1, 1, 0); tick;
        put(6, 0, 0, 1, 1, 1, 0, 0); #1;
        n_vec++;
        if ({pc_en, idex_bubble} !== 2'b10) begin
            n_err++; $display("FAIL load_use_x0: got %b want 10", {pc_en, idex_bubble});
        end
    endtask

    task automatic test_forwarding;
        do_reset;
        put(7, 1, 0, 1, 0, 1, 0, 0); tick;
        put(8, 7, 7, 1, 1, 1, 0, 0); tick;
        nop; #1;
        n_vec++;
        if ({fwd_a, fwd_b} !== 4'b1010) begin
            n_err++; $display("FAIL fwd_adjacent: got a=%0d b=%0d want 2 2", fwd_a, fwd_b);
        end
        do_reset;
        put(7, 1, 0, 1, 0, 1, 0, 0); tick;
        put(9, 2, 0, 1, 0, 1, 0, 0); tick;
        put(8, 7, 7, 1, 1, 1, 0, 0); tick;
        nop; #1;
        n_vec++;
        if ({fwd_a, fwd_b} !== 4'b1111) begin
            n_err++; $display("FAIL fwd_gap: got a=%0d b=%0d want 3 3", fwd_a, fwd_b);
        end
        do_reset;
        put(0, 1, 0, 1, 0, 1, 0, 0); tick;
        put(8, 0, 0, 1, 1, 1, 0, 0); tick;
        nop; #1;
        n_vec++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin
            n_err++; $display("FAIL fwd_x0: got a=%0d b=%0d want 0 0", fwd_a, fwd_b);
        end
        do_reset;
        put(7, 1, 0, 1, 0, 1, 0, 0); tick;
        put(7, 2, 0, 1, 0, 1, 0, 0); tick;
        put(8, 7, 7, 1, 1, 1, 0, 0); tick;
        nop; #1;
        n_vec++;
        if ({fwd_a, fwd_b} !== 4'b1010) begin
            n_err++; $display("FAIL fwd_nearest: got a=%0d b=%0d want 2 2", fwd_a, fwd_b);
        end
        do_reset;
        put(7, 1, 2, 1, 1, 0, 0, 0); tick;
        put(8, 7, 7, 1, 1, 1, 0, 0); tick;
        nop; #1;
        n_vec++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin
            n_err++; $display("FAIL fwd_no_regwrite: got a=%0d b=%0d want 0 0", fwd_a, fwd_b);
        end
    endtask

    task automatic test_fpu_done;
        do_reset;
        put(10, 1, 2, 1, 1, 1, 0, 1); tick;
        put(11, 2, 0, 1, 0, 1, 0, 0); #1;
        n_vec++;
        if ({fpu_busy, pc_en} !== 2'b01) begin
            n_err++; $display("FAIL fpu_enter_cycle: got %b want 01", {fpu_busy, pc_en});
        end
        tick; nop;
        for (int i = 1; i <= 5; i++) begin
            fpu_done = (i == 5); #1;
            n_vec++;
            if ({fpu_busy, pc_en, ifid_en, fpu_timeout} !== 4'b1000) begin
                n_err++; $display("FAIL fpu_busy_cycle%0d: got %b want 1000", i, {fpu_busy, pc_en, ifid_en, fpu_timeout});
            end
            tick;
        end
        fpu_done = 0; #1;
        n_vec++;
        if ({fpu_busy, pc_en, fpu_timeout} !== 3'b010) begin
            n_err++; $display("FAIL fpu_done_exit: got %b want 010", {fpu_busy, pc_en, fpu_timeout});
        end
        fpu_done = 1; tick; fpu_done = 0; #1;
        n_vec++;
        if ({fpu_busy, pc_en} !== 2'b01) begin
            n_err++; $display("FAIL fpu_done_idle_ignored: got %b want 01", {fpu_busy, pc_en});
        end
    endtask

    task automatic test_fpu_timeout;
        logic exp_to;
        do_reset;
        put(10, 1, 2, 1, 1, 1, 0, 1); tick;
        nop; tick;
        for (int i = 1; i <= 16; i++) begin
            exp_to = (i == 16);
            #1;
            n_vec++;
            if ({fpu_busy, fpu_timeout} !== {1'b1, exp_to}) begin
                n_err++; $display("FAIL fpu_timeout_cycle%0d: got %b want %b", i, {fpu_busy, fpu_timeout}, {1'b1, exp_to});
            end
            tick;
        end
        #1;
        n_vec++;
        if ({fpu_busy, fpu_timeout, pc_en} !== 3'b001) begin
            n_err++; $display("FAIL fpu_timeout_exit: got %b want 001", {fpu_busy, fpu_timeout, pc_en});
        end
    endtask

    task automatic test_branch;
        do_reset;
        put(7, 1, 0, 1, 0, 1, 0, 0); tick;
        put(8, 7, 7, 1, 1, 1, 0, 0); branch_taken = 1; #1;
        n_vec++;
        if ({ifid_flush, flush_mask, pc_en, ifid_en} !== 6'b1_001_11) begin
            n_err++; $display("FAIL branch_idle: got %b want 100111", {ifid_flush, flush_mask, pc_en, ifid_en});
        end
        tick; branch_taken = 0; nop; #1;
        n_vec++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin
            n_err++; $display("FAIL branch_kill_fwd: got a=%0d b=%0d want 0 0", fwd_a, fwd_b);
        end
        do_reset;
        put(5, 1, 0, 1, 0, 1, 1, 0); tick;
        put(6, 5, 1, 1, 1, 1, 0, 0); branch_taken = 1; #1;
        n_vec++;
        if ({pc_en, idex_bubble, ifid_flush} !== 3'b101) begin
            n_err++; $display("FAIL branch_over_load_use: got %b want 101", {pc_en, idex_bubble, ifid_flush});
        end
        branch_taken = 0;
    endtask

    task automatic test_branch_busy;
        do_reset;
        put(10, 1, 2, 1, 1, 1, 0, 1); tick;
        nop; tick; tick;
        branch_taken = 1; #1;
        n_vec++;
        if ({ifid_flush, flush_mask, pc_en, fpu_busy, fpu_timeout} !== 7'b1_001_1_1_0) begin
            n_err++; $display("FAIL branch_busy: got %b want 1001110", {ifid_flush, flush_mask, pc_en, fpu_busy, fpu_timeout});
        end
        tick; branch_taken = 0; #1;
        n_vec++;
        if ({fpu_busy, pc_en} !== 2'b01) begin
            n_err++; $display("FAIL branch_busy_exit: got %b want 01", {fpu_busy, pc_en});
        end
        tick;
        n_vec++;
        if (fpu_busy !== 1'b0) begin
            n_err++; $display("FAIL branch_busy_no_reentry: got %b want 0", fpu_busy);
        end
        do_reset;
        put(10, 1, 2, 1, 1, 1, 0, 1); tick;
        nop; tick;
        for (int i = 1; i <= 15; i++) tick;
        branch_taken = 1; #1;
        n_vec++;
        if ({fpu_timeout, pc_en, fpu_busy} !== 3'b011) begin
            n_err++; $display("FAIL branch_on_last_cycle: got %b want 011", {fpu_timeout, pc_en, fpu_busy});
        end
        tick; branch_taken = 0; #1;
        n_vec++;
        if ({fpu_busy, fpu_timeout} !== 2'b00) begin
            n_err++; $display("FAIL branch_last_exit: got %b want 00", {fpu_busy, fpu_timeout});
        end
    endtask

    task automatic test_reset_mid_busy;
        do_reset;
        put(10, 1, 2, 1, 1, 1, 0, 1); tick;
        nop; tick; tick;
        n_vec++;
        if (fpu_busy !== 1'b1) begin
            n_err++; $display("FAIL midbusy_pre: got %b want 1", fpu_busy);
        end
        clear = 0; #1;
        n_vec++;
        if ({fpu_busy, pc_en, ifid_en} !== 3'b011) begin
            n_err++; $display("FAIL midbusy_abort: got %b want 011", {fpu_busy, pc_en, ifid_en});
        end
        tick; clear = 1;
        put(10, 1, 2, 1, 1, 1, 0, 1); tick;
        nop; #1;
        n_vec++;
        if ({fpu_busy, pc_en} !== 2'b01) begin
            n_err++; $display("FAIL midbusy_fresh_idle: got %b want 01", {fpu_busy, pc_en});
        end
        tick;
        n_vec++;
        if ({fpu_busy, pc_en} !== 2'b10) begin
            n_err++; $display("FAIL midbusy_fresh_busy: got %b want 10", {fpu_busy, pc_en});
        end
    endtask

    task automatic test_float;
        logic [1:0] exp_f0, exp_x3;
`ifdef FLOAT_RF_EN
        exp_f0 = 2'd2; exp_x3 = 2'd0;
`else
        exp_f0 = 2'd0; exp_x3 = 2'd2;
`endif
        do_reset;
        put(0, 1, 0, 1, 0, 1, 0, 0); id_float_rd = 1; tick;
        put(8, 0, 0, 1, 0, 1, 0, 0); id_float_rs1 = 1; tick;
        nop; #1;
        n_vec++;
        if (fwd_a !== exp_f0) begin
            n_err++; $display("FAIL float_f0: got %0d want %0d", fwd_a, exp_f0);
        end
        do_reset;
        put(3, 1, 0, 1, 0, 1, 0, 0); tick;
        put(8, 3, 0, 1, 0, 1, 0, 0); id_float_rs1 = 1; tick;
        nop; #1;
        n_vec++;
        if (fwd_a !== exp_x3) begin
            n_err++; $display("FAIL float_int_vs_float: got %0d want %0d", fwd_a, exp_x3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        nop; branch_taken = 0; fpu_done = 0;
        test_reset;
        test_load_use;
        test_forwarding;
        test_fpu_done;
        test_fpu_timeout;
        test_branch;
        test_branch_busy;
        test_reset_mid_busy;
        test_float;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
